// File: rtl/matrix_disp_pkg.sv
// Shared types and constants for the matrix display scanner: segment glyphs,
// anode encodings and the matrix location enum.
package matrix_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        LOC_A = 2'd0,
        LOC_B = 2'd1,
        LOC_C = 2'd2,
        LOC_D = 2'd3
    } loc_e;

    function automatic loc_e loc_next(input loc_e cur);
        loc_e nxt;
        nxt = LOC_A;
        unique case (cur)
            LOC_A: nxt = LOC_B;
            LOC_B: nxt = LOC_C;
            LOC_C: nxt = LOC_D;
            LOC_D: nxt = LOC_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module seg7_hex_dec
    import matrix_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/matrix_disp_scan.sv
// 4-digit seven-segment scanner with frame-aligned value latch and matrix location stepper.
// Optional anti-ghosting blank window enabled by defining MATRIX_DISP_GHOST_BLANK_EN.
module matrix_disp_scan
    import matrix_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned LOC_HOLD    = 500,
    parameter int unsigned BLANK_CYC   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] val_in,
    input  logic        hold,
    input  logic        step,
    output logic [1:0]  matrix_loc,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FW = (LOC_HOLD > 1) ? $clog2(LOC_HOLD) : 1;

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    dig_idx_q, dig_idx_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]   val_lat_q, val_lat_d;
    loc_e          loc_q, loc_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;

    logic          refresh_tc, frame_tc, auto_adv, blank, ghost;
    logic [3:0]    nibble;
    logic [6:0]    glyph;

    // Scan timing and the frame-aligned latch, so a new value never tears mid-frame
    always_comb begin
        refresh_tc    = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
        frame_tc      = refresh_tc && (dig_idx_q == 2'd3);
        refresh_cnt_d = refresh_tc ? '0 : refresh_cnt_q + RW'(1);
        dig_idx_d     = refresh_tc ? dig_idx_q + 2'd1 : dig_idx_q;
        val_lat_d     = frame_tc ? val_in : val_lat_q;
    end

    always_comb begin
        nibble = 4'h0;
        unique case (dig_idx_q)
            2'd0: nibble = val_lat_q[3:0];
            2'd1: nibble = val_lat_q[7:4];
            2'd2: nibble = val_lat_q[11:8];
            2'd3: nibble = val_lat_q[15:12];
        endcase
    end

    seg7_hex_dec u_dec (
        .hex (nibble),
        .seg (glyph)
    );

`ifdef MATRIX_DISP_GHOST_BLANK_EN
    assign ghost = (32'(refresh_cnt_q) < BLANK_CYC);
`else
    logic unused_blank_cyc;
    assign unused_blank_cyc = ^BLANK_CYC;
    assign ghost = 1'b0;
`endif

    // Leading-zero blanking only on the middle digits; the letter and ones digit always show
    always_comb begin
        blank   = ((dig_idx_q == 2'd2) && (val_lat_q[11:8] == 4'h0)) ||
                  ((dig_idx_q == 2'd1) && (val_lat_q[11:4] == 8'h00));
        seg_d   = blank ? SEG_BLANK : glyph;
        anode_d = ghost ? ANODE_OFF : ~(4'b0001 << dig_idx_q);
    end

    // Location stepper: hold dominates, then step or auto-advance move by exactly one
    always_comb begin
        loc_d       = loc_q;
        frame_cnt_d = frame_cnt_q;
        auto_adv    = frame_tc && (frame_cnt_q == FW'(LOC_HOLD - 1));
        if (hold) begin
            frame_cnt_d = '0;
        end else if (step || auto_adv) begin
            loc_d       = loc_next(loc_q);
            frame_cnt_d = '0;
        end else if (frame_tc) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            dig_idx_q     <= 2'd0;
            frame_cnt_q   <= '0;
            val_lat_q     <= 16'h0000;
            loc_q         <= LOC_A;
            anode_q       <= ANODE_OFF;
            seg_q         <= SEG_BLANK;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            dig_idx_q     <= dig_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            val_lat_q     <= val_lat_d;
            loc_q         <= loc_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
        end
    end

    assign matrix_loc = loc_q;
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_matrix_disp_scan.sv
// Randomized bench for matrix_disp_scan against a cycle-count based reference model.
module tb_matrix_disp_scan;

    localparam int RD = 4;
    localparam int LH = 2;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] val_in;
    logic        hold;
    logic        step;
    logic [1:0]  matrix_loc;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: cycles since reset release, latched word, location, frames since advance
    int unsigned m_cyc;
    logic [15:0] m_lat;
    int          m_loc;
    int          m_frames;
    logic [6:0]  glyph_tab [16];

    matrix_disp_scan #(
        .REFRESH_DIV (RD),
        .LOC_HOLD    (LH),
        .BLANK_CYC   (BC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .val_in     (val_in),
        .hold       (hold),
        .step       (step),
        .matrix_loc (matrix_loc),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Advance the model over one edge, then compare the registered outputs just after it
    task automatic tick();
        logic [3:0]  ea;
        logic [6:0]  es;
        logic [15:0] sh;
        int          slot;
        int          pos;
        bit          boundary;
        bit          blank;
        if (!rst_n) begin
            ea       = 4'b1111;
            es       = 7'b1111111;
            m_cyc    = 0;
            m_lat    = 16'h0000;
            m_loc    = 0;
            m_frames = 0;
        end else begin
            slot  = int'((m_cyc / RD) % 4);
            pos   = int'(m_cyc % RD);
            sh    = m_lat >> (4 * slot);
            blank = (slot == 2 && m_lat[11:8] == 4'h0) || (slot == 1 && m_lat[11:4] == 8'h00);
            es    = blank ? 7'b1111111 : glyph_tab[sh[3:0]];
            case (slot)
                0:       ea = 4'b1110;
                1:       ea = 4'b1101;
                2:       ea = 4'b1011;
                default: ea = 4'b0111;
            endcase
`ifdef MATRIX_DISP_GHOST_BLANK_EN
            if (pos < BC) ea = 4'b1111;
`else
            if (pos < 0) ea = 4'b1111;
`endif
            boundary = ((m_cyc % (4 * RD)) == (4 * RD - 1));
            if (boundary) m_lat = val_in;
            if (hold) begin
                m_frames = 0;
            end else begin
                if (boundary) m_frames++;
                if (step || m_frames == LH) begin
                    m_loc    = (m_loc + 1) % 4;
                    m_frames = 0;
                end
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        check_eq("anode", {12'h0, anode}, {12'h0, ea});
        check_eq("seg", {9'h0, seg}, {9'h0, es});
        check_eq("dp", {15'h0, dp}, 16'h0001);
        check_eq("matrix_loc", {14'h0, matrix_loc}, 16'(m_loc));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int loc_save;
        int guard;
        glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
        glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
        glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
        glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
        glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
        glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;

        rst_n  = 1'b0;
        val_in = 16'hA017;
        hold   = 1'b0;
        step   = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(48);

        // New value mid-frame only appears after the next boundary
        run(6);
        val_in = 16'hC105;
        run(40);

        // Free-running auto-advance through a full wrap
        run(140);

        // Step coinciding with an auto-advance moves by exactly one
        guard = 0;
        while (!((m_cyc % (4 * RD)) == (4 * RD - 1) && m_frames == LH - 1) && guard < 100) begin
            tick();
            guard++;
        end
        check_eq("align_bound", 16'(guard < 100), 16'h0001);
        loc_save = m_loc;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("step_on_auto", {14'h0, matrix_loc}, 16'((loc_save + 1) % 4));
        run(40);

        // Hold freezes location despite steps and elapsed frames
        hold = 1'b1;
        loc_save = m_loc;
        for (int i = 0; i < 160; i++) begin
            step = ($urandom_range(0, 3) == 0);
            tick();
        end
        step = 1'b0;
        check_eq("hold_frozen", {14'h0, matrix_loc}, 16'(loc_save));
        hold = 1'b0;
        run(40);

        // One-cycle reset in the middle of a slot
        guard = 0;
        while ((m_cyc % RD) != 2 && guard < 10) begin
            tick();
            guard++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(40);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) val_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) hold = ~hold;
            step  = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
            tick();
        end
        rst_n = 1'b1;
        hold  = 1'b0;
        step  = 1'b0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
